ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction prefetch unit between a variable-latency instruction memory and the fetch/decode pipeline register.
- Issues in-order fetch requests and buffers returned instructions with their PC+2 in a small FIFO.
- Presents a valid/ready stream to decode and handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.
- The fetch/decode register loads on out_valid & out_ready.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUT, 2, max outstanding memory requests (1..DEPTH)
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
mem_req  output  1  fetch request valid
mem_addr  output  16  fetch address
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  response valid (in request order)
mem_rdata  input  16  instruction word
out_valid  output  1  head entry valid
out_instr  output  16  head instruction
out_pc2  output  16  head instruction address + 2
out_ready  input  1  decode consumes head
redirect  input  1  flush and refetch (one-cycle pulse)
redirect_pc  input  16  new fetch address; bit 0 forced to 0
halt  input  1  stop issuing new fetches
err  output  1  protocol error flag

Behaviour:
- Reset (rst low, async):
  - fetch_pc = resp_pc = RESET_PC; FIFO count 0; outstanding 0; drop 0.
  - out_valid = 0, mem_req = 0, err = 0; state IDLE.
- States:
  - IDLE -> FETCH unconditionally on the first clock after rst deasserts.
  - FETCH -> HALTED when halt=1 and redirect=0.
  - HALTED -> FETCH only on redirect. HALTED never issues requests.
- Request issue (FETCH only, combinational):
  - mem_req = !redirect & !halt & (outstanding < MAX_OUT) & (count + outstanding < DEPTH).
  - mem_addr = fetch_pc.
  - Accepted on mem_req & mem_gnt: fetch_pc += 2 (16-bit wrap, FFFE -> 0000), outstanding++.
- Response:
  - mem_rvalid & drop>0: drop--, outstanding--, nothing pushed.
  - mem_rvalid & drop==0: push {mem_rdata, resp_pc+2}, resp_pc += 2 (wrap), outstanding--.
  - The reservation rule guarantees no push into a full FIFO.
- Output and pop:
  - out_valid = (count != 0); out_instr/out_pc2 driven from the head register, zero-latency.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: with mem_gnt=1 and a 1-cycle response, the first out_valid occurs 3 cycles after reset release. Steady state is 1 instruction/cycle.
- Redirect (highest priority, any state except IDLE), in the redirect cycle:
  - mem_req = 0; any pop is ignored.
  - Any mem_rvalid arriving that cycle is discarded.
  - Next state: count = 0, out_valid = 0; fetch_pc = resp_pc = {redirect_pc[15:1],1'b0}.
  - drop = outstanding after this cycle's response; state FETCH.
- Halt:
  - In-flight responses are still accepted and the FIFO still drains to decode.
  - halt is level-sensitive; deasserting it in HALTED does not resume fetching.
- Counters: width clog2(DEPTH)+1; pointers wrap modulo DEPTH.

Optional Feature:
- Macro IFQ_ERR_EN.
- When defined: err is sticky and set on either of:
  - mem_rvalid with outstanding == 0;
  - mem_gnt with mem_req == 0.
- err clears only on reset.
- When undefined: err tied to 0 and no checking logic is generated.

Test Plan:
1. Reset release, mem_gnt=1, 1-cycle response returning word = address, out_ready=1 -> mem_addr 0000, 0002, ...; out_pc2 stream 0002, 0004, 0006 with out_instr 0000, 0002, 0004; no bubbles after first valid.
2. out_ready=0 from start -> count reaches 4, mem_req drops with outstanding 0. Raise out_ready -> instructions 0000..0006 in order, then fetching resumes at 0008.
3. 3-cycle latency, 2 outstanding (addrs 0004, 0006), redirect to 0x0100 -> both late responses dropped; next out_pc2 = 0102, next mem_addr = 0100.
4. halt=1 with 2 outstanding -> no further mem_req; both instructions still delivered. Clearing halt alone -> still no mem_req; redirect to 0x0040 -> fetching resumes at 0040.
5. Redirect to FFFE -> out_pc2 0000 for the first entry; next mem_addr 0000.
6. IFQ_ERR_EN defined: mem_rvalid with nothing outstanding -> err=1 next cycle and held until rst low. Undefined: err stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Instruction prefetch FIFO between variable-latency memory and
//            decode, with redirect flush. Optional macro IFQ_ERR_EN adds a
//            sticky protocol error flag.
// Revision : 1.0
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc2,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_max_out = CW'(MAX_OUT);
    localparam logic [CW-1:0] c_full    = CW'(DEPTH);
    localparam logic [CW:0]   c_depth   = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   instr_q [DEPTH];
    logic [15:0]   pc2_q   [DEPTH];

    logic          w_redir;
    logic [CW:0]   w_occ;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;

    assign w_redir = redirect & (state_q != ST_IDLE);
    // Slots already reserved: buffered entries plus requests still in flight.
    assign w_occ   = {1'b0, count_q} + {1'b0, outst_q};
    assign w_req   = (state_q == ST_FETCH) & ~redirect & ~halt
                   & (outst_q < c_max_out) & (w_occ < c_depth);
    assign w_grant = w_req & mem_gnt;
    assign w_push  = mem_rvalid & (drop_q == '0) & ~w_redir & (count_q != c_full);
    assign w_pop   = (count_q != '0) & out_ready & ~w_redir;

    assign mem_req   = w_req;
    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_q[rd_ptr_q];
    assign out_pc2   = pc2_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (w_grant) begin
            fetch_pc_d = fetch_pc_q + 16'd2;
            outst_d    = outst_d + 1'b1;
        end
        if (mem_rvalid && (outst_q != '0)) begin
            outst_d = outst_d - 1'b1;
        end
        if (mem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (w_push) begin
            resp_pc_d = resp_pc_q + 16'd2;
            wr_ptr_d  = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        // Redirect overrides everything; responses still in flight are
        // counted into drop so they are discarded when they return.
        if (w_redir) begin
            state_d    = ST_FETCH;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[15:1], 1'b0};
            resp_pc_d  = {redirect_pc[15:1], 1'b0};
            drop_d     = outst_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            instr_q[wr_ptr_q] <= mem_rdata;
            pc2_q[wr_ptr_q]   <= resp_pc_q + 16'd2;
        end
    end

`ifdef IFQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (mem_rvalid & (outst_q == '0)) | (mem_gnt & ~w_req);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Purpose  : Randomised scoreboard bench for ifetch_queue with a queue-based
//            memory and fetch-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_ifetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc2;
    logic        out_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        err;

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc2    (out_pc2),
        .out_ready  (out_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
    } ent_t;

    req_t        pend[$];
    ent_t        sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          fifo_m     = 0;
    int          st_m       = 0;   // 0 idle, 1 fetching, 2 halted
    logic [15:0] fpc_m      = 16'h0000;
    bit          err_m      = 1'b0;
    bit          mon_en     = 1'b1;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit rdy, input bit hlt, input bit rd, input logic [15:0] rpc,
                         input int gpct, input int lat);
        bit   rsp;
        bit   exp_req;
        bit   pop_m;
        req_t e;
        @(negedge clk);
        out_ready   = rdy;
        halt        = hlt;
        redirect    = rd;
        redirect_pc = rpc;
        rsp         = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rvalid  = rsp;
        mem_rdata   = rsp ? memf(pend[0].addr) : 16'($urandom);
        mem_gnt     = 1'b0;
        #1;
        mem_gnt = mem_req && ($urandom_range(99) < gpct);
        #1;
        exp_req = (st_m == 1) && !rd && !hlt && (pend.size() < MAX_OUT)
                && (fifo_m + pend.size() < DEPTH);
        chk("mem_req", mem_req, exp_req);
        chk("out_valid", out_valid, fifo_m != 0);
        chk("err", err, err_m);
        pop_m = (fifo_m != 0) && rdy && !rd;
        if (mem_req && mem_gnt) begin
            chk("mem_addr", mem_addr, fpc_m);
            sb.push_back('{memf(fpc_m), fpc_m + 16'd2});
            pend.push_back('{mem_addr, cyc + lat, 1'b0});
            fpc_m = fpc_m + 16'd2;
        end
        if (rsp) begin
            e = pend.pop_front();
            if (!e.stale && !rd) fifo_m++;
        end
        if (pop_m) fifo_m--;
        if (rd && st_m != 0) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            sb.delete();
            fifo_m = 0;
            fpc_m  = {rpc[15:1], 1'b0};
            st_m   = 1;
        end else if (st_m == 0) begin
            st_m = 1;
        end else if (st_m == 1 && hlt) begin
            st_m = 2;
        end
    endtask

    // Monitor: pops the scoreboard on every accepted head entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en && rst && out_valid && out_ready && !redirect) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow at cycle %0d: got pc2 %h expected no entry", cyc, out_pc2);
                end else begin
                    e = sb.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_pc2", out_pc2, e.pc2);
                end
            end
        end
    end

    initial begin
        bit hl_lvl;
        bit rd;
        rst = 1'b0;
        out_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        repeat (2) begin
            @(negedge clk);
            #2;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_err", err, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // Streaming with single-cycle memory.
        repeat (12) cycle(1, 0, 0, 16'h0, 100, 1);
        // Back-pressure fills the FIFO, then drains.
        repeat (10) cycle(0, 0, 0, 16'h0, 100, 1);
        repeat (10) cycle(1, 0, 0, 16'h0, 100, 1);
        // Slow memory, redirect with two requests in flight.
        repeat (6) cycle(1, 0, 0, 16'h0, 100, 3);
        cycle(1, 0, 1, 16'h0100, 100, 3);
        repeat (10) cycle(1, 0, 0, 16'h0, 100, 3);
        // Halt with requests in flight, release alone, then redirect.
        repeat (2) cycle(1, 0, 0, 16'h0, 100, 3);
        repeat (6) cycle(1, 1, 0, 16'h0, 100, 3);
        repeat (3) cycle(1, 0, 0, 16'h0, 100, 3);
        cycle(1, 0, 1, 16'h0040, 100, 1);
        repeat (8) cycle(1, 0, 0, 16'h0, 100, 1);
        // Redirect near the top of the address space (bit 0 ignored).
        cycle(1, 0, 1, 16'hFFFF, 100, 1);
        repeat (8) cycle(1, 0, 0, 16'h0, 100, 1);

        hl_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) hl_lvl = ~hl_lvl;
            rd = (st_m != 0) && ($urandom_range(99) < 3);
            cycle($urandom_range(99) < 70, hl_lvl, rd, 16'($urandom),
                  $urandom_range(100, 40), $urandom_range(4, 1));
        end

        for (int i = 0; i < 60 && pend.size() != 0; i++) cycle(0, 1, 0, 16'h0, 100, 1);
        cycle(0, 1, 0, 16'h0, 100, 1);
        chk("drain", pend.size(), 0);

        // Stray response with nothing outstanding.
        mon_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b0; halt = 1'b1; redirect = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
`ifdef IFQ_ERR_EN
        err_m = 1'b1;
`endif
        repeat (3) begin
            #2;
            chk("err_sticky", err, err_m);
            @(negedge clk);
        end
        rst = 1'b0;
        #2;
        chk("rst2_err", err, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_mem_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
